// File: rtl/regfile_pkg.sv
// Shared types and defaults for the register file and the core top level.
package regfile_pkg;

   typedef enum logic {RF_CLEAR, RF_RUN} rf_state_t;

   localparam int RF_XLEN      = 32;
   localparam int RF_REG_COUNT = 32;
   localparam int ZERO_ADDR    = 0;

endpackage

// File: rtl/regfile_clear_sequencer.sv
// Post-reset clear sweep: walks every register once writing zero, then
// raises ready and hands the write port back to writeback.
module regfile_clear_sequencer
   import regfile_pkg::*;
#(
   parameter int REG_COUNT      = RF_REG_COUNT,
   parameter int ADDR_WIDTH     = 5,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   output logic                  ready,
   output logic                  clear_we,
   output logic [ADDR_WIDTH-1:0] clear_addr
);

   // one extra bit so the counter can reach REG_COUNT without wrapping
   localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH+1)'(REG_COUNT - 1);

   rf_state_t             state, state_nxt;
   logic [ADDR_WIDTH:0]   sweep_count, sweep_nxt;

   // state and sweep counter; reset restarts the sweep from the top
   always_ff @(posedge clock) begin
      if (!reset) begin
         state       <= RF_CLEAR;
         sweep_count <= '0;
      end else begin
         state       <= state_nxt;
         sweep_count <= sweep_nxt;
      end
   end

   // next state and clear-port drive
   always_comb begin
      state_nxt  = state;
      sweep_nxt  = sweep_count;
      clear_we   = 1'b0;
      clear_addr = sweep_count[ADDR_WIDTH-1:0];
      case (state)
         RF_CLEAR: begin
            if (CLEAR_ON_RESET != 0) begin
               clear_we  = 1'b1;
               sweep_nxt = sweep_count + 1'b1;
               if (sweep_count == LAST) state_nxt = RF_RUN;
            end else begin
               state_nxt = RF_RUN;
            end
         end
         RF_RUN:  state_nxt = RF_RUN;
         default: state_nxt = RF_CLEAR;
      endcase
   end

   assign ready = (state == RF_RUN);

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised register file: one write port, NUM_READ read ports with
// write-to-read bypass, optional hard-wired zero register and clear sweep.
module regfile_multiport
   import regfile_pkg::*;
#(
   parameter int XLEN            = RF_XLEN,
   parameter int REG_COUNT       = RF_REG_COUNT,
   parameter int ADDR_WIDTH      = 5,
   parameter int NUM_READ        = 2,
   parameter int READ_REGISTERED = 0,
   parameter int ZERO_REG        = 1,
   parameter int CLEAR_ON_RESET  = 1
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           write_enable,
   input  logic [ADDR_WIDTH-1:0]          register_write_select,
   input  logic [XLEN-1:0]                register_data_write,
   input  logic [NUM_READ*ADDR_WIDTH-1:0] rs,
   output logic [NUM_READ*XLEN-1:0]       register_data,
   output logic                           ready
);

   localparam logic [ADDR_WIDTH:0]   COUNT_W = (ADDR_WIDTH+1)'(REG_COUNT);
   localparam logic [ADDR_WIDTH-1:0] ZERO_A  = ADDR_WIDTH'(ZERO_ADDR);

   logic                  clear_we;
   logic [ADDR_WIDTH-1:0] clear_addr;
   logic                  wr_ok;

   logic [XLEN-1:0] mem [REG_COUNT];

   logic [NUM_READ-1:0][ADDR_WIDTH-1:0] rs_a;
   logic [NUM_READ-1:0][XLEN-1:0]       rd_val;

   regfile_clear_sequencer #(
      .REG_COUNT      (REG_COUNT),
      .ADDR_WIDTH     (ADDR_WIDTH),
      .CLEAR_ON_RESET (CLEAR_ON_RESET)
   ) u_seq (
      .clock      (clock),
      .reset      (reset),
      .ready      (ready),
      .clear_we   (clear_we),
      .clear_addr (clear_addr)
   );

   // out-of-range and zero-register writes are dropped here, not in the array
   assign wr_ok = ready && write_enable
                  && ({1'b0, register_write_select} < COUNT_W)
                  && !((ZERO_REG != 0) && (register_write_select == ZERO_A));

   // storage: clear sweep owns the port until ready; nothing changes in reset
   always_ff @(posedge clock) begin
      if (reset) begin
         if (clear_we)   mem[clear_addr]            <= '0;
         else if (wr_ok) mem[register_write_select] <= register_data_write;
      end
   end

   assign rs_a = rs;

   for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
      logic [XLEN-1:0] val;
      // per-port read: forced zero, then bypass, then stored value
      always_comb begin
         if (!ready || ({1'b0, rs_a[i]} >= COUNT_W)
             || ((ZERO_REG != 0) && (rs_a[i] == ZERO_A)))
            val = '0;
         else if (write_enable && (register_write_select == rs_a[i]))
            val = register_data_write;
         else
            val = mem[rs_a[i]];
      end
      assign rd_val[i] = val;
   end

   if (READ_REGISTERED != 0) begin : g_rdq
      logic [NUM_READ-1:0][XLEN-1:0] rd_q;
      // registered read: bypass is resolved before the flop
      always_ff @(posedge clock) begin
         if (!reset) rd_q <= '0;
         else        rd_q <= rd_val;
      end
      assign register_data = rd_q;
   end else begin : g_rdc
      assign register_data = rd_val;
   end

endmodule
